// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline with debug drain and perf counters
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_WAIT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [1:0]       ID_UsesRs,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Busy,
  input  logic             halt_req,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             IDEX_en,
  output logic             IDEX_flush,
  output logic             EXMEM_en,
  output logic             MEMWB_bubble,
  output logic             halted,
  output logic             wait_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] W_LAST = WW'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic [WW-1:0] wait_cnt;
  logic lu_raw, hold, busy, branch, draining, run_like, stall_ev;
  // hazard classification in priority order: busy > branch > load-use > halt
  always_comb begin
    lu_raw   = EX_MemRead && EX_rd != 5'd0 &&
               ((ID_UsesRs[0] && ID_rs1 == EX_rd) || (ID_UsesRs[1] && ID_rs2 == EX_rd));
    busy     = state != HALTED && MEM_Busy;
    hold     = state == HALTED || busy;
    branch   = !hold && EX_BranchTaken;
    draining = !hold && state == DRAIN && halt_req;
    run_like = !hold && !draining;
    stall_ev = run_like && !branch && lu_raw;
  end
  // Mealy control outputs; reset forces a frozen, flushed pipeline
  always_comb begin
    PC_en        = rst_n && !hold && (branch || !(draining || stall_ev));
    IFID_en      = rst_n && !hold && !draining && !stall_ev;
    IFID_flush   = !rst_n || branch;
    IDEX_en      = rst_n && !hold;
    IDEX_flush   = !rst_n || branch || draining || stall_ev;
    EXMEM_en     = rst_n && !hold;
    MEMWB_bubble = !rst_n || hold;
  end
  // next-state: busy freezes, a drain cycle counts even with a branch, halt_req drop aborts drain
  always_comb begin
    state_n = state;
    drain_n = drain_cnt;
    if (state == HALTED) state_n = halt_req ? HALTED : RUN;
    else if (draining) begin
      state_n = drain_cnt == D_LAST ? HALTED : DRAIN;
      drain_n = drain_cnt == D_LAST ? '0 : drain_cnt + 1'b1;
    end else if (run_like) begin
      state_n = (halt_req && !branch && !stall_ev) ? DRAIN : RUN;
      drain_n = '0;
    end
  end
  // state, busy-wait tracking and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      drain_cnt    <= '0;
      wait_cnt     <= '0;
      halted       <= 1'b0;
      wait_timeout <= 1'b0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      state        <= state_n;
      drain_cnt    <= drain_n;
      halted       <= state_n == HALTED;
      wait_cnt     <= busy ? (wait_cnt == W_MAX ? wait_cnt : wait_cnt + 1'b1) : '0;
      wait_timeout <= wait_timeout || (busy && wait_cnt >= W_LAST);
      stall_count  <= (stall_ev && stall_count != C_MAX) ? stall_count + 1'b1 : stall_count;
      flush_count  <= (branch && flush_count != C_MAX) ? flush_count + 1'b1 : flush_count;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus randomized checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam int DC = 3;
  localparam int MW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic [1:0] ID_UsesRs = '0;
  logic EX_MemRead = 0, EX_BranchTaken = 0, MEM_Busy = 0, halt_req = 0;
  logic PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble, halted, wait_timeout;
  logic [CW-1:0] stall_count, flush_count;
  logic [6:0] ctl;
  int checks = 0, errors = 0;
  int m_state = 0, m_dc = 0, m_wc = 0, m_stall = 0, m_flush = 0;
  bit m_to = 0;
  pipe_hazard_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_UsesRs(ID_UsesRs),
    .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Busy(MEM_Busy), .halt_req(halt_req), .PC_en(PC_en), .IFID_en(IFID_en),
    .IFID_flush(IFID_flush), .IDEX_en(IDEX_en), .IDEX_flush(IDEX_flush), .EXMEM_en(EXMEM_en),
    .MEMWB_bubble(MEMWB_bubble), .halted(halted), .wait_timeout(wait_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );
  assign ctl = {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit load_use();
    return EX_MemRead && EX_rd != 0 &&
           ((ID_UsesRs[0] && ID_rs1 == EX_rd) || (ID_UsesRs[1] && ID_rs2 == EX_rd));
  endfunction
  // expected {PC_en,IFID_en,IFID_flush,IDEX_en,IDEX_flush,EXMEM_en,MEMWB_bubble}
  function automatic logic [6:0] exp_ctl();
    if (!rst_n) return 7'b0010101;
    if (m_state == 2 || MEM_Busy) return 7'b0000001;
    if (m_state == 1 && halt_req) return EX_BranchTaken ? 7'b1011110 : 7'b0001110;
    if (EX_BranchTaken) return 7'b1111110;
    if (load_use()) return 7'b0001110;
    return 7'b1101010;
  endfunction
  task automatic model_reset();
    m_state = 0; m_dc = 0; m_wc = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask
  task automatic model_edge();
    if (m_state == 2) begin
      m_wc = 0;
      if (!halt_req) m_state = 0;
    end else if (MEM_Busy) begin
      m_wc = m_wc < MW ? m_wc + 1 : MW;
      if (m_wc >= MW) m_to = 1;
    end else begin
      m_wc = 0;
      if (EX_BranchTaken && m_flush < CMAX) m_flush++;
      if (m_state == 1 && halt_req) begin
        m_dc++;
        if (m_dc == DC) begin m_state = 2; m_dc = 0; end
      end else begin
        m_dc = 0;
        if (!EX_BranchTaken && load_use()) begin
          if (m_stall < CMAX) m_stall++;
          m_state = 0;
        end else m_state = (!EX_BranchTaken && halt_req) ? 1 : 0;
      end
    end
  endtask
  // called just after a negedge with inputs applied; returns at the next negedge
  task automatic step(input string tag);
    #1;
    chk({tag, " ctl"}, 32'(ctl), 32'(exp_ctl()));
    chk({tag, " halted"}, 32'(halted), 32'(m_state == 2));
    chk({tag, " timeout"}, 32'(wait_timeout), 32'(m_to));
    chk({tag, " stall_count"}, 32'(stall_count), 32'(m_stall));
    chk({tag, " flush_count"}, 32'(flush_count), 32'(m_flush));
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask
  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] uses,
                        input logic [4:0] rd, input logic mr, input logic br, input logic bsy,
                        input logic hr);
    ID_rs1 = rs1; ID_rs2 = rs2; ID_UsesRs = uses; EX_rd = rd;
    EX_MemRead = mr; EX_BranchTaken = br; MEM_Busy = bsy; halt_req = hr;
  endtask
  initial begin
    @(negedge clk);
    repeat (3) step("reset");
    rst_n = 1'b1;
    step("post_reset");
    set_in(1, 5, 2'b10, 5, 1, 0, 0, 0); step("load_use");
    chk("lu count", 32'(stall_count), 32'd1);
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 0); step("lu_clear");
    set_in(0, 0, 2'b11, 0, 1, 0, 0, 0); step("lu_rd0");
    set_in(5, 5, 2'b00, 5, 1, 0, 0, 0); step("lu_nouse");
    set_in(5, 5, 2'b01, 5, 1, 0, 0, 0); step("lu_rs1");
    set_in(5, 5, 2'b11, 5, 1, 1, 0, 0); step("branch_lu");
    set_in(0, 0, 2'b00, 0, 0, 1, 1, 0);
    repeat (4) step("busy_branch");
    set_in(0, 0, 2'b00, 0, 0, 1, 0, 0); step("branch_after_busy");
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 0); step("idle");
    chk("timeout sticky", 32'(wait_timeout), 32'd1);
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 1); step("halt_req");
    step("drain0");
    set_in(0, 0, 2'b00, 0, 0, 0, 1, 1); repeat (2) step("drain_busy");
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 1); step("drain1");
    step("drain2");
    chk("halted set", 32'(halted), 32'd1);
    set_in(0, 0, 2'b00, 0, 0, 0, 1, 1); step("halted_busy");
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 0); step("unhalt");
    chk("halted clear", 32'(halted), 32'd0);
    step("resume");
    set_in(3, 7, 2'b01, 3, 1, 0, 0, 0);
    repeat (21) step("saturate");
    chk("stall saturated", 32'(stall_count), 32'(CMAX));
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 1); step("halt2");
    step("drain_a");
    rst_n = 1'b0;
    model_reset();
    step("async_reset");
    rst_n = 1'b1;
    set_in(0, 0, 2'b00, 0, 0, 0, 0, 0); step("after_reset");
    chk("run after reset", 32'(PC_en), 32'd1);
    for (int i = 0; i < 500; i++) begin
      ID_rs1 = 5'($urandom_range(0, 3));
      ID_rs2 = 5'($urandom_range(0, 3));
      ID_UsesRs = 2'($urandom);
      EX_rd = 5'($urandom_range(0, 3));
      EX_MemRead = $urandom_range(0, 1) == 1;
      EX_BranchTaken = $urandom_range(0, 99) < 15;
      MEM_Busy = $urandom_range(0, 99) < 20;
      if ($urandom_range(0, 99) < 6) halt_req = ~halt_req;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step("rand_reset");
        rst_n = 1'b1;
      end else step("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives enables and flushes for PC, IF/ID, ID/EX, EX/MEM, and a bubble control for MEM/WB.
- Resolves four hazard classes: data-memory wait, taken-branch flush, load-use stall, and debug halt with pipeline drain.
- Keeps saturating performance counters and a sticky memory-wait timeout flag.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- DRAIN_CYCLES, 3, non-busy bubble cycles inserted before HALTED is entered.
- MAX_WAIT, 255, consecutive MEM_Busy cycles that set wait_timeout.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs1  in  5  source register 1 of the instruction in ID.
- ID_rs2  in  5  source register 2 of the instruction in ID.
- ID_UsesRs  in  2  bit0: ID reads rs1; bit1: ID reads rs2.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  EX instruction is a load.
- EX_BranchTaken  in  1  EX resolved a taken branch or jump.
- MEM_Busy  in  1  data memory not ready this cycle.
- halt_req  in  1  debug halt request, level.
- PC_en  out  1  PC register load enable.
- IFID_en  out  1  IF/ID load enable.
- IFID_flush  out  1  IF/ID clear to NOP.
- IDEX_en  out  1  ID/EX load enable.
- IDEX_flush  out  1  ID/EX load NOP (control bits zero).
- EXMEM_en  out  1  EX/MEM load enable.
- MEMWB_bubble  out  1  MEM/WB loads RegWrite=0, MemToReg=0.
- halted  out  1  pipeline drained and frozen; registered.
- wait_timeout  out  1  sticky; registered.
- stall_count  out  CNT_W  load-use stall cycles; saturating; registered.
- flush_count  out  CNT_W  branch flush events; saturating; registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to RUN; drain_cnt, wait_cnt and both counters go to 0; halted=0; wait_timeout=0.
  - Control outputs are forced while reset is held: all *_en=0, IFID_flush=1, IDEX_flush=1, MEMWB_bubble=1.
- FSM states: RUN, DRAIN, HALTED. Control outputs are combinational from state and inputs (Mealy).
- Default (RUN, no hazard): all *_en=1, flushes=0, MEMWB_bubble=0.
- Priority in RUN and DRAIN: MEM_Busy > EX_BranchTaken > load-use > halt_req.
- MEM_Busy=1 (RUN or DRAIN):
  - Outputs: PC_en=IFID_en=IDEX_en=EXMEM_en=0, flushes=0, MEMWB_bubble=1.
  - State and drain_cnt hold.
  - wait_cnt increments per consecutive busy cycle and clears on the first non-busy cycle.
  - wait_cnt reaching MAX_WAIT sets wait_timeout, which is cleared only by reset.
- Taken branch (no busy):
  - Outputs: IFID_flush=1, IDEX_flush=1, PC_en=1; other enables 1.
  - flush_count += 1. Load-use detection is masked that cycle.
- Load-use (no busy, no branch): asserted when all of the following hold:
  - EX_MemRead=1 and EX_rd!=0;
  - (ID_UsesRs[0] and ID_rs1==EX_rd) or (ID_UsesRs[1] and ID_rs2==EX_rd).
  - Outputs: PC_en=0, IFID_en=0, IDEX_flush=1; EXMEM_en=1, IDEX_en=1.
  - stall_count += 1.
  - Exactly one bubble per hazard: the next cycle the load is in MEM, so the comparison naturally clears.
- halt_req=1 in RUN with no busy, branch or load-use: default outputs this cycle; next state DRAIN with drain_cnt=0.
- DRAIN, non-busy cycle:
  - Outputs: PC_en=0, IFID_en=0, IDEX_flush=1.
  - drain_cnt += 1. When drain_cnt==DRAIN_CYCLES-1 on this cycle, next state is HALTED.
  - A taken branch in DRAIN additionally sets PC_en=1 and IFID_flush=1 so the target is retained; the cycle still counts.
- halt_req=0 during DRAIN: abort; next state RUN, drain_cnt=0.
- HALTED:
  - Outputs: all *_en=0, flushes=0, MEMWB_bubble=1; halted=1.
  - MEM_Busy is ignored; counters hold.
  - halt_req=0 → RUN on the next edge; halted=0 from that edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous busy+branch: busy wins. The branch must still be asserted once busy drops, because EX is frozen.

Test Plan:
- Reset held 3 cycles, release: required outputs during reset are enables=0, flushes=1, bubble=1; first cycle after release, all enables=1, counters=0, halted=0.
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs2=5, ID_UsesRs=2'b10: required one cycle with PC_en=0, IFID_en=0, IDEX_flush=1, stall_count=1. Repeat with EX_rd=0 and with ID_UsesRs=0: required no stall.
- Branch with a load-use hazard present in the same cycle: required IFID_flush=IDEX_flush=1, PC_en=1, flush_count=1, stall_count unchanged.
- MEM_Busy high 4 cycles with EX_BranchTaken=1 throughout:
  - required: 4 freeze cycles with MEMWB_bubble=1, then one flush cycle, flush_count=1.
  - MAX_WAIT=3 variant: wait_timeout=1, still set after busy drops.
- halt_req held, DRAIN_CYCLES=3, MEM_Busy injected for 2 cycles mid-drain: required 3 bubble cycles excluding busy, then halted=1. Deassert halt_req: halted=0 next edge, enables=1.
- 2^CNT_W+5 load-use stalls with CNT_W=4: required stall_count=15, no wrap. Assert rst_n low mid-DRAIN: required immediate RUN and halted=0.
